// File: rtl/rvfi_commit_serializer.sv
// Serializes up to NR_COMMIT_PORTS RVFI commit records per cycle into a single-record FIFO stream.
// Optional: define RVFI_SERIALIZER_TRAP_EN so trap-only records (valid=0, trap=1) also qualify.
package rvfi_pkg;
  typedef struct packed {
    logic        valid;
    logic        trap;
    logic        intr;
    logic [1:0]  mode;
    logic [31:0] insn;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
  } rvfi_instr_t;
endpackage

module rvfi_commit_serializer #(
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned DEPTH           = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  rvfi_pkg::rvfi_instr_t       rvfi_i [NR_COMMIT_PORTS],
  output rvfi_pkg::rvfi_instr_t       rvfi_o,
  output logic [63:0]                 seq_o,
  output logic                        valid_o,
  input  logic                        ready_i,
  input  logic                        flush_i,
  input  logic                        clr_i,
  output logic [$clog2(DEPTH+1)-1:0]  count_o,
  output logic [31:0]                 drop_cnt_o,
  output logic                        overflow_o
);
  localparam int unsigned   CW      = $clog2(DEPTH + 1);
  localparam int unsigned   PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  rvfi_pkg::rvfi_instr_t r_mem     [DEPTH];
  logic [63:0]           r_seq_mem [DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [63:0]           r_seq;
  logic [31:0]           r_drop_cnt;
  logic                  r_overflow;

  logic [NR_COMMIT_PORTS-1:0] w_qual;
  logic [CW-1:0]              w_q;
  logic [PW-1:0]              w_wr_idx [NR_COMMIT_PORTS];
  logic [63:0]                w_wr_seq [NR_COMMIT_PORTS];
  logic [PW-1:0]              w_wr_ptr_nxt;
  logic [PW-1:0]              w_rd_ptr_nxt;
  logic [CW-1:0]              w_free;
  logic                       w_push;
  logic                       w_drop;
  logic                       w_pop;
  logic [31:0]                w_drop_base;
  logic [32:0]                w_drop_sum;
  logic [31:0]                w_drop_nxt;

  // Each qualifying port lands at wr_ptr + (number of lower-indexed qualifying ports).
  always_comb begin
    w_qual = '0;
    w_q    = '0;
    for (int unsigned i = 0; i < NR_COMMIT_PORTS; i++) begin
`ifdef RVFI_SERIALIZER_TRAP_EN
      w_qual[i] = rvfi_i[i].valid | rvfi_i[i].trap;
`else
      w_qual[i] = rvfi_i[i].valid;
`endif
      w_wr_idx[i] = PW'((32'(r_wr_ptr) + 32'(w_q)) % DEPTH);
      w_wr_seq[i] = r_seq + 64'(w_q);
      w_q         = w_q + CW'(w_qual[i]);
    end
  end

  always_comb begin
    w_wr_ptr_nxt = PW'((32'(r_wr_ptr) + 32'(w_q)) % DEPTH);
    w_rd_ptr_nxt = PW'((32'(r_rd_ptr) + 32'd1) % DEPTH);
    w_free       = DEPTH_C - r_count;
    w_push       = (w_q <= w_free) && !flush_i;
    w_drop       = (w_q > w_free) && !flush_i;
    w_pop        = valid_o && ready_i && !flush_i;
    w_drop_base  = clr_i ? '0 : r_drop_cnt;
    w_drop_sum   = {1'b0, w_drop_base} + 33'(w_q);
    w_drop_nxt   = w_drop_sum[32] ? '1 : w_drop_sum[31:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_seq      <= '0;
      r_drop_cnt <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_seq <= r_seq + 64'(w_q);
      if (flush_i) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= w_wr_ptr_nxt;
        if (w_pop)  r_rd_ptr <= w_rd_ptr_nxt;
        r_count <= r_count + (w_push ? w_q : '0) - CW'(w_pop);
      end
      // A drop in the clear cycle restarts the statistics from this cycle's drop.
      if (w_drop) begin
        r_drop_cnt <= w_drop_nxt;
        r_overflow <= 1'b1;
      end else if (clr_i) begin
        r_drop_cnt <= '0;
        r_overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      for (int unsigned i = 0; i < NR_COMMIT_PORTS; i++) begin
        if (w_qual[i]) begin
          r_mem[w_wr_idx[i]]     <= rvfi_i[i];
          r_seq_mem[w_wr_idx[i]] <= w_wr_seq[i];
        end
      end
    end
  end

  assign valid_o    = (r_count != '0);
  assign rvfi_o     = valid_o ? r_mem[r_rd_ptr] : '0;
  assign seq_o      = valid_o ? r_seq_mem[r_rd_ptr] : '0;
  assign count_o    = r_count;
  assign drop_cnt_o = r_drop_cnt;
  assign overflow_o = r_overflow;

endmodule

// File: tb/tb_rvfi_commit_serializer.sv
// Bench for rvfi_commit_serializer: directed scenarios plus random traffic against a queue model.
module tb_rvfi_commit_serializer;
  import rvfi_pkg::*;

  localparam int unsigned NR    = 2;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  rvfi_instr_t rvfi_i [NR];
  rvfi_instr_t rvfi_o;
  logic [63:0] seq_o;
  logic        valid_o;
  logic        ready_i;
  logic        flush_i;
  logic        clr_i;
  logic [CW-1:0] count_o;
  logic [31:0] drop_cnt_o;
  logic        overflow_o;

  rvfi_commit_serializer #(.NR_COMMIT_PORTS(NR), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .rvfi_i(rvfi_i), .rvfi_o(rvfi_o), .seq_o(seq_o),
    .valid_o(valid_o), .ready_i(ready_i), .flush_i(flush_i), .clr_i(clr_i),
    .count_o(count_o), .drop_cnt_o(drop_cnt_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    rvfi_instr_t rec;
    logic [63:0] seq;
  } entry_t;

  entry_t            m_q[$];
  logic [63:0]       m_seq;
  longint unsigned   m_drop;
  bit                m_ovf;
  int unsigned       n_checks = 0;
  int unsigned       n_errors = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit qualifies(input rvfi_instr_t r);
`ifdef RVFI_SERIALIZER_TRAP_EN
    return r.valid || r.trap;
`else
    return r.valid;
`endif
  endfunction

  task automatic check_outputs(input string tag);
    bit          v;
    rvfi_instr_t er;
    logic [63:0] es;
    v  = (m_q.size() != 0);
    er = '0;
    es = '0;
    if (v) begin
      er = m_q[0].rec;
      es = m_q[0].seq;
    end
    check({tag, ".valid"}, 256'(valid_o), 256'(v));
    check({tag, ".rvfi"},  256'(rvfi_o), 256'(er));
    check({tag, ".seq"},   256'(seq_o), 256'(es));
    check({tag, ".count"}, 256'(count_o), 256'(m_q.size()));
    check({tag, ".drop"},  256'(drop_cnt_o), 256'(m_drop));
    check({tag, ".ovf"},   256'(overflow_o), 256'(m_ovf));
  endtask

  task automatic model_step();
    entry_t          newq[$];
    int unsigned     q;
    int unsigned     free;
    bit              dropped;
    longint unsigned base;
    q    = 0;
    free = DEPTH - m_q.size();
    for (int i = 0; i < NR; i++) begin
      if (qualifies(rvfi_i[i])) begin
        newq.push_back('{rec: rvfi_i[i], seq: m_seq});
        m_seq++;
        q++;
      end
    end
    dropped = !flush_i && (q > free);
    if (flush_i) begin
      m_q.delete();
    end else begin
      if (m_q.size() != 0 && ready_i) void'(m_q.pop_front());
      if (!dropped) foreach (newq[k]) m_q.push_back(newq[k]);
    end
    if (dropped) begin
      base   = clr_i ? 0 : m_drop;
      m_drop = base + q;
      if (m_drop > 64'hFFFF_FFFF) m_drop = 64'hFFFF_FFFF;
      m_ovf  = 1'b1;
    end else if (clr_i) begin
      m_drop = 0;
      m_ovf  = 1'b0;
    end
  endtask

  task automatic tick(input string tag);
    check_outputs(tag);
    model_step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic set_port(input int i, input bit v, input bit t, input logic [31:0] pc);
    rvfi_i[i].valid    = v;
    rvfi_i[i].trap     = t;
    rvfi_i[i].intr     = 1'($urandom());
    rvfi_i[i].mode     = 2'($urandom());
    rvfi_i[i].insn     = $urandom();
    rvfi_i[i].pc_rdata = pc;
    rvfi_i[i].pc_wdata = pc + 32'd4;
    rvfi_i[i].rd_addr  = 5'($urandom());
    rvfi_i[i].rd_wdata = $urandom();
  endtask

  task automatic idle_ports();
    for (int i = 0; i < NR; i++) rvfi_i[i] = '0;
  endtask

  task automatic push_n(input int n);
    for (int i = 0; i < NR; i++) set_port(i, (i < n), 1'b0, $urandom() & 32'hFFFF_FFFC);
    tick("push");
    idle_ports();
  endtask

  // Asserted away from a clock edge so the asynchronous clear is observed directly.
  task automatic pulse_reset(input string tag);
    rst_ni = 1'b0;
    #1;
    check({tag, ".valid"}, 256'(valid_o), 256'(0));
    check({tag, ".rvfi"},  256'(rvfi_o), 256'(0));
    check({tag, ".seq"},   256'(seq_o), 256'(0));
    check({tag, ".count"}, 256'(count_o), 256'(0));
    check({tag, ".drop"},  256'(drop_cnt_o), 256'(0));
    check({tag, ".ovf"},   256'(overflow_o), 256'(0));
    m_q.delete();
    m_seq  = '0;
    m_drop = 0;
    m_ovf  = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    idle_ports();
    ready_i = 1'b0;
    flush_i = 1'b0;
    clr_i   = 1'b0;
    m_seq   = '0;
    m_drop  = 0;
    m_ovf   = 1'b0;
    @(negedge clk_i);
    pulse_reset("rst0");

    // Two in-order commits, drained one per cycle.
    set_port(0, 1'b1, 1'b0, 32'h8000_0000);
    set_port(1, 1'b1, 1'b0, 32'h8000_0004);
    ready_i = 1'b1;
    tick("s31a");
    idle_ports();
    check("s31.pc0", 256'(rvfi_o.pc_rdata), 256'(32'h8000_0000));
    check("s31.seq0", 256'(seq_o), 256'(0));
    tick("s31b");
    check("s31.pc1", 256'(rvfi_o.pc_rdata), 256'(32'h8000_0004));
    check("s31.seq1", 256'(seq_o), 256'(1));
    tick("s31c");

    // Fill to full, then an all-or-nothing drop.
    pulse_reset("rst32");
    ready_i = 1'b0;
    repeat (4) push_n(2);
    check("s32.full", 256'(count_o), 256'(8));
    check("s32.noovf", 256'(overflow_o), 256'(0));
    push_n(2);
    check("s32.count", 256'(count_o), 256'(8));
    check("s32.drop", 256'(drop_cnt_o), 256'(2));
    check("s32.ovf", 256'(overflow_o), 256'(1));
    ready_i = 1'b1;
    tick("s32pop");
    ready_i = 1'b0;
    push_n(1);
    ready_i = 1'b1;
    repeat (7) tick("s32drain");
    check("s32.seq10", 256'(seq_o), 256'(10));
    tick("s32last");

    // Free space is taken before the same-cycle pop.
    pulse_reset("rst33");
    ready_i = 1'b0;
    repeat (3) push_n(2);
    push_n(1);
    check("s33.seven", 256'(count_o), 256'(7));
    ready_i = 1'b1;
    push_n(2);
    check("s33.count", 256'(count_o), 256'(6));
    check("s33.drop", 256'(drop_cnt_o), 256'(2));

    // Flush discards buffered and incoming records but still advances seq.
    pulse_reset("rst34");
    ready_i = 1'b0;
    repeat (2) push_n(2);
    push_n(1);
    set_port(0, 1'b1, 1'b0, 32'h1000);
    flush_i = 1'b1;
    ready_i = 1'b1;
    tick("s34flush");
    flush_i = 1'b0;
    ready_i = 1'b0;
    idle_ports();
    check("s34.count", 256'(count_o), 256'(0));
    check("s34.valid", 256'(valid_o), 256'(0));
    push_n(1);
    check("s34.seq", 256'(seq_o), 256'(6));
    check("s34.drop", 256'(drop_cnt_o), 256'(0));

    // Trap-only record on port 0.
    pulse_reset("rst35");
    set_port(0, 1'b0, 1'b1, 32'h2000);
    tick("s35");
    idle_ports();
`ifdef RVFI_SERIALIZER_TRAP_EN
    check("s35.count", 256'(count_o), 256'(1));
`else
    check("s35.count", 256'(count_o), 256'(0));
`endif

    // Reset mid-burst; numbering restarts from zero.
    pulse_reset("rst36a");
    ready_i = 1'b0;
    push_n(2);
    push_n(1);
    check("s36.three", 256'(count_o), 256'(3));
    pulse_reset("rst36b");
    push_n(1);
    check("s36.seq0", 256'(seq_o), 256'(0));
    check("s36.valid", 256'(valid_o), 256'(1));

    // Random traffic alternating between congested and draining phases.
    pulse_reset("rstrnd");
    for (int i = 0; i < 800; i++) begin
      for (int p = 0; p < NR; p++)
        set_port(p, ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 15), $urandom() & 32'hFFFF_FFFC);
      ready_i = ($urandom_range(0, 99) < (((i / 100) % 2 == 0) ? 25 : 85));
      flush_i = ($urandom_range(0, 99) < 2);
      clr_i   = ($urandom_range(0, 99) < 4);
      tick("rnd");
    end
    idle_ports();
    flush_i = 1'b0;
    clr_i   = 1'b0;
    tick("end");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rvfi_commit_serializer.md
RVFI_COMMIT_SERIALIZER -- requirements
Module: rvfi_commit_serializer

Interface
REQ-001 SHALL have parameter NR_COMMIT_PORTS, default 2: number of RVFI commit ports sampled per cycle (1..4).
REQ-002 SHALL have parameter DEPTH, default 8: FIFO entries; a power of two no smaller than NR_COMMIT_PORTS.
REQ-003 SHALL have port clk_i, input, 1: the single clock; one clock, reset is asynchronous and active-low.
REQ-004 SHALL have port rst_ni, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port rvfi_i, input, NR_COMMIT_PORTS x rvfi_pkg::rvfi_instr_t: commit records, where port 0 is the oldest in program order.
REQ-006 SHALL have port rvfi_o, output, rvfi_pkg::rvfi_instr_t: head record.
REQ-007 SHALL have port seq_o, output, 64: commit sequence number of the head record.
REQ-008 SHALL have port valid_o, output, 1: head record present.
REQ-009 SHALL have port ready_i, input, 1: sink accepts the head record.
REQ-010 SHALL have port flush_i, input, 1: synchronous FIFO flush.
REQ-011 SHALL have port clr_i, input, 1: synchronous clear of the drop statistics.
REQ-012 SHALL have port count_o, output, $clog2(DEPTH+1): current occupancy.
REQ-013 SHALL have port drop_cnt_o, output, 32: number of dropped records, saturating.
REQ-014 SHALL have port overflow_o, output, 1: sticky flag, set once any drop occurs.

Function
REQ-015 SHALL treat a port as qualifying in a cycle when rvfi_i[i].valid is 1 (see REQ-030 for trap-only records).
REQ-016 SHALL let Q be the number of qualifying ports and free = DEPTH - count_o, sampled before any pop in that cycle.
REQ-017 SHALL, when Q <= free, push all Q qualifying records in ascending port index in that same cycle.
REQ-018 SHALL, when Q > free, push none of that cycle's qualifying records, so that admission is all-or-nothing.
REQ-019 SHALL, on such a drop, add Q to drop_cnt_o, saturating at 32'hFFFFFFFF, and set overflow_o.
REQ-020 SHALL tag each qualifying record with a running 64-bit sequence number that starts at 0, increments once per qualifying record (dropped or not), wraps modulo 2^64, and is stored alongside the record.
REQ-021 SHALL drive valid_o = (count_o != 0), with rvfi_o and seq_o showing the head entry; when valid_o is 0, rvfi_o and seq_o SHALL be all zero.
REQ-022 SHALL pop the head when valid_o && ready_i; rvfi_o and seq_o SHALL hold stable while valid_o && !ready_i.
REQ-023 SHALL have a latency of 1 cycle: a record pushed in cycle N appears at the head no earlier than cycle N+1.
REQ-024 SHALL allow a push and a pop in the same cycle, with count_o' = count_o + pushed - popped.
REQ-025 SHALL, on flush_i, empty the FIFO at the next edge, so count_o = 0.
- Records presented in the flush cycle SHALL be discarded; they advance seq and are not counted in drop_cnt_o.
- A pop in the flush cycle SHALL be ignored.
REQ-026 SHALL, on clr_i, zero drop_cnt_o and overflow_o; if a drop occurs in the same cycle, the drop SHALL win (drop_cnt_o = Q, overflow_o = 1).
REQ-027 SHALL use circular read/write pointers of $clog2(DEPTH) bits that wrap at DEPTH, and a separate occupancy counter to tell full from empty.

Reset
REQ-028 SHALL, while rst_ni is 0, immediately force: count_o=0, valid_o=0, rvfi_o=0, seq_o=0, drop_cnt_o=0, overflow_o=0, pointers=0, sequence counter=0.
REQ-029 SHALL, on reset mid-operation, lose all buffered records; storage contents need not be cleared but SHALL never be visible while valid_o is 0.

Configuration
REQ-030 SHALL support macro RVFI_SERIALIZER_TRAP_EN.
- When defined: a port with valid=0 and trap=1 also qualifies and is pushed as-is.
- When undefined: such records are ignored and do not advance seq.

Verification
REQ-031 SHALL cover: ports 0 and 1 valid with pc 0x80000000 and 0x80000004, ready_i=1 -> next cycles emit 0x80000000 then 0x80000004, with seq_o 0 then 1.
REQ-032 SHALL cover: ready_i=0 and 4 cycles of 2 valid ports with DEPTH=8 -> count_o=8, overflow_o=0; a fifth dual commit -> count_o=8, drop_cnt_o=2, overflow_o=1, and the next accepted record has seq 10.
REQ-033 SHALL cover: count_o=7 with 2 valid ports, one of them popping -> nothing pushed, drop_cnt_o += 2, count_o=6.
REQ-034 SHALL cover: flush_i with count_o=5 and 1 valid port -> count_o=0, valid_o=0 next cycle, with seq advanced by 1.
REQ-035 SHALL cover: trap-only record on port 0 -> enqueued with the macro defined, ignored without it.
REQ-036 SHALL cover: rst_ni pulsed low mid-burst with count_o=3 -> all outputs 0 asynchronously, and the first record after release has seq_o=0.
